burst_ram_arbiter: RTL and testbench

BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

---
 rtl/burst_ram_arbiter_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 27 ++
 rtl/burst_ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_arbiter_pkg.sv
// Shared definitions for the burst RAM arbiter: FSM state encoding,
// BurstRAM command codes and requester identifiers.
package burst_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_WR_BURST = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with a last-grant register.
// Ports: clk, rst_n, req_a_i/req_b_i requests, take_i (grant consumed),
// gnt_b_o (1 = B wins, 0 = A wins or no request).
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic take_i,
    output logic gnt_b_o
);

    // 1 = B was granted last; reset to "A last" so B wins first.
    logic last_b_q;

    // On contention the port that was not granted last wins.
    assign gnt_b_o = req_b_i & (~req_a_i | ~last_b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_q <= 1'b0;
        end else if (take_i) begin
            last_b_q <= gnt_b_o;
        end
    end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Arbitrates a read/write data port (A) and a read-only instruction port (B)
// onto a single BurstRAM, one burst outstanding at a time.
// Ports: clk, rst (async active-low); port A a_*; port B b_*; BurstRAM br_*.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 8,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 a_req,
    input  logic                                 a_cmd,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        a_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   a_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] a_wr_mask,
    output logic                                 a_wr_next,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   a_rd_data,
    output logic                                 a_rd_valid,
    output logic                                 a_done,
    input  logic                                 b_req,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        b_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   b_rd_data,
    output logic                                 b_rd_valid,
    output logic                                 b_done,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);

    localparam int BW = RAM_BURST_DATA_BITWIDTH;
    localparam int MW = BW / 8;
    localparam int CW = $clog2(RAM_BURST_DATA_COUNT);
    localparam logic [CW-1:0] LAST_BEAT = CW'(RAM_BURST_DATA_COUNT - 1);

    state_e                        state_q;
    logic [CW-1:0]                 cnt_q;
    logic                          sel_b_q;
    logic                          br_cmd_q;
    logic                          br_cmd_en_q;
    logic [RAM_DEPTH_BITWIDTH-1:0] br_addr_q;
    logic                          wr_next_q;
    logic                          a_done_q;
    logic                          b_done_q;

    logic grant;
    logic gnt_b;
    logic gnt_cmd;
    logic rd_beat;

    assign grant   = (state_q == ST_IDLE) & ~br_busy & (a_req | b_req);
    assign gnt_cmd = gnt_b ? CMD_READ : a_cmd;
    assign rd_beat = (state_q == ST_RD_WAIT) & br_rd_data_valid;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst),
        .req_a_i (a_req),
        .req_b_i (b_req),
        .take_i  (grant),
        .gnt_b_o (gnt_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_b_q     <= PORT_A;
            br_cmd_q    <= CMD_READ;
            br_cmd_en_q <= 1'b0;
            br_addr_q   <= '0;
            wr_next_q   <= 1'b0;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
        end else begin
            br_cmd_en_q <= 1'b0;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        sel_b_q     <= gnt_b;
                        br_cmd_q    <= gnt_cmd;
                        br_addr_q   <= gnt_b ? b_addr : a_addr;
                        br_cmd_en_q <= 1'b1;
                        cnt_q       <= '0;
                        if (gnt_cmd == CMD_WRITE) begin
                            // Beat 0 goes out alongside br_cmd_en.
                            wr_next_q <= 1'b1;
                            state_q   <= ST_WR_BURST;
                        end else begin
                            state_q   <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (br_rd_data_valid) begin
                        if (cnt_q == LAST_BEAT) begin
                            cnt_q    <= '0;
                            a_done_q <= ~sel_b_q;
                            b_done_q <= sel_b_q;
                            state_q  <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                ST_WR_BURST: begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_q     <= '0;
                        wr_next_q <= 1'b0;
                        a_done_q  <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign br_cmd    = br_cmd_q;
    assign br_cmd_en = br_cmd_en_q;
    assign br_addr   = br_addr_q;
    assign a_wr_next = wr_next_q;
    assign a_done    = a_done_q;
    assign b_done    = b_done_q;

    // The requester presents the current beat; a_wr_next acknowledges it.
    assign br_wr_data   = wr_next_q ? a_wr_data : '0;
    assign br_data_mask = wr_next_q ? ~a_wr_mask : {MW{1'b1}};

    // Read beats pass straight through to the granted port only.
    assign a_rd_valid = rd_beat & ~sel_b_q;
    assign b_rd_valid = rd_beat & sel_b_q;
    assign a_rd_data  = a_rd_valid ? br_rd_data : '0;
    assign b_rd_data  = b_rd_valid ? br_rd_data : '0;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Scoreboard bench for burst_ram_arbiter: directed bursts push expected
// bus commands, beats and done pulses; a monitor pops and compares them.
module tb_burst_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        a_req, a_cmd;
    logic [7:0]  a_addr;
    logic [63:0] a_wr_data;
    logic [7:0]  a_wr_mask;
    logic        a_wr_next;
    logic [63:0] a_rd_data;
    logic        a_rd_valid, a_done;
    logic        b_req;
    logic [7:0]  b_addr;
    logic [63:0] b_rd_data;
    logic        b_rd_valid, b_done;
    logic        br_cmd, br_cmd_en;
    logic [7:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        br_busy;

    logic        rsp_valid, stray_valid;
    logic [63:0] rsp_data, stray_data;
    int          rsp_stop;

    logic [63:0] wr_arr [0:7];
    logic [2:0]  wr_idx;

    logic [8:0]  exp_cmd_q [$];
    logic [64:0] exp_rd_q [$];
    logic [71:0] exp_wr_q [$];
    logic        exp_done_q [$];
    logic [63:0] bus_data_q [$];

    int n_pass, n_total;
    int done_a, done_b, rd_seen;

    assign br_rd_data_valid = rsp_valid | stray_valid;
    assign br_rd_data       = rsp_valid ? rsp_data : stray_data;
    assign a_wr_data        = wr_arr[wr_idx];

    burst_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_cmd(a_cmd), .a_addr(a_addr),
        .a_wr_data(a_wr_data), .a_wr_mask(a_wr_mask),
        .a_wr_next(a_wr_next), .a_rd_data(a_rd_data),
        .a_rd_valid(a_rd_valid), .a_done(a_done),
        .b_req(b_req), .b_addr(b_addr), .b_rd_data(b_rd_data),
        .b_rd_valid(b_rd_valid), .b_done(b_done),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [127:0] act);
        n_total++;
        $display("FAIL %s: got unexpected %0h required nothing", name, act);
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (br_cmd_en) begin
                if (exp_cmd_q.size() == 0) unexpected("cmd", {br_cmd, br_addr});
                else chk("cmd", {br_cmd, br_addr}, exp_cmd_q.pop_front());
                if (br_cmd) chk("wr_next_with_cmd_en", a_wr_next, 1'b1);
            end
            if (a_rd_valid || b_rd_valid) begin
                rd_seen++;
                chk("rd_valid_exclusive", a_rd_valid & b_rd_valid, 1'b0);
                if (exp_rd_q.size() == 0)
                    unexpected("rd_beat", {b_rd_valid, a_rd_data | b_rd_data});
                else
                    chk("rd_beat", {b_rd_valid, b_rd_valid ? b_rd_data : a_rd_data},
                        exp_rd_q.pop_front());
            end
            if (a_wr_next) begin
                if (exp_wr_q.size() == 0) unexpected("wr_beat", {br_data_mask, br_wr_data});
                else chk("wr_beat", {br_data_mask, br_wr_data}, exp_wr_q.pop_front());
            end else begin
                chk("idle_wr_bus", {br_data_mask, br_wr_data}, {8'hFF, 64'h0});
            end
            if (a_done || b_done) begin
                if (a_done) done_a++;
                if (b_done) done_b++;
                chk("done_exclusive", a_done & b_done, 1'b0);
                if (exp_done_q.size() == 0) unexpected("done", {a_done, b_done});
                else chk("done_port", b_done, exp_done_q.pop_front());
            end
        end
    end

    // BurstRAM read responder
    initial begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst && br_cmd_en && !br_cmd) begin
                for (int i = 0; i < 4 && i < rsp_stop; i++) begin
                    @(posedge clk); #1;
                    rsp_valid = 1'b1;
                    rsp_data  = (bus_data_q.size() != 0) ? bus_data_q.pop_front() : 64'h0;
                end
                @(posedge clk); #1;
                rsp_valid = 1'b0;
                rsp_data  = '0;
            end
        end
    end

    // Port A write-data source: advance one beat per acknowledged a_wr_next
    initial begin
        logic adv, req_s;
        wr_idx = '0;
        forever begin
            @(negedge clk);
            adv   = a_wr_next;
            req_s = a_req;
            @(posedge clk); #1;
            if (!req_s) wr_idx = '0;
            else if (adv && wr_idx != 3'd7) wr_idx = wr_idx + 3'd1;
        end
    end

    task automatic push_read(input logic port_b, input logic [7:0] addr,
                             input logic [63:0] base);
        exp_cmd_q.push_back({1'b0, addr});
        for (int i = 0; i < 4; i++) begin
            exp_rd_q.push_back({port_b, base + 64'(i)});
            bus_data_q.push_back(base + 64'(i));
        end
        exp_done_q.push_back(port_b);
    endtask

    task automatic push_write(input logic [7:0] addr, input logic [7:0] mask,
                              input logic [63:0] base);
        exp_cmd_q.push_back({1'b1, addr});
        for (int i = 0; i < 4; i++) begin
            wr_arr[i] = base + 64'(i);
            exp_wr_q.push_back({~mask, base + 64'(i)});
        end
        exp_done_q.push_back(1'b0);
    endtask

    task automatic wait_done(input logic port_b, input int base, input string tag);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        while (n < 200 && !ok) begin
            @(posedge clk);
            n++;
            if ((port_b ? done_b : done_a) > base) ok = 1'b1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s: got no done pulse required one", tag);
        end
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, {br_cmd_en, br_cmd, a_wr_next, a_rd_valid,
                            a_done, b_rd_valid, b_done}, 7'b0);
        chk({tag, "_wr"}, {br_data_mask, br_wr_data}, {8'hFF, 64'h0});
        chk({tag, "_data"}, {br_addr, a_rd_data, b_rd_data}, 136'h0);
    endtask

    initial begin
        int ba, bb, n;
        n_pass = 0; n_total = 0;
        done_a = 0; done_b = 0; rd_seen = 0;
        rst = 1'b0; a_req = 1'b0; a_cmd = 1'b0; a_addr = '0;
        a_wr_mask = '0; b_req = 1'b0; b_addr = '0; br_busy = 1'b0;
        stray_valid = 1'b0; stray_data = '0; rsp_stop = 4;
        for (int i = 0; i < 8; i++) wr_arr[i] = '0;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Contention right after reset: B first, then A
        ba = done_a; bb = done_b;
        push_read(1'b1, 8'h40, 64'h4000);
        push_read(1'b0, 8'h30, 64'h3000);
        a_cmd = 1'b0; a_addr = 8'h30; a_req = 1'b1;
        b_addr = 8'h40; b_req = 1'b1;
        wait_done(1'b1, bb, "contend1_b");
        b_req = 1'b0;
        wait_done(1'b0, ba, "contend1_a");
        a_req = 1'b0;

        // Single B read, addr 0x12, beats 0x11..0x44
        bb = done_b;
        exp_cmd_q.push_back({1'b0, 8'h12});
        for (int i = 1; i <= 4; i++) begin
            exp_rd_q.push_back({1'b1, 64'(i * 8'h11)});
            bus_data_q.push_back(64'(i * 8'h11));
        end
        exp_done_q.push_back(1'b1);
        b_addr = 8'h12; b_req = 1'b1;
        wait_done(1'b1, bb, "read_b");
        b_req = 1'b0;

        // Contention again, B was last: A (write) first, then B
        ba = done_a; bb = done_b;
        push_write(8'h06, 8'h0F, 64'hB0);
        push_read(1'b1, 8'h41, 64'h4100);
        a_cmd = 1'b1; a_addr = 8'h06; a_wr_mask = 8'h0F; a_req = 1'b1;
        b_addr = 8'h41; b_req = 1'b1;
        wait_done(1'b0, ba, "contend2_a");
        a_req = 1'b0;
        wait_done(1'b1, bb, "contend2_b");
        b_req = 1'b0;

        // A write addr 0x05, beats 0xA0..0xA3, mask 0x00
        ba = done_a;
        push_write(8'h05, 8'h00, 64'hA0);
        a_cmd = 1'b1; a_addr = 8'h05; a_wr_mask = 8'h00; a_req = 1'b1;
        wait_done(1'b0, ba, "write_a");
        a_req = 1'b0;

        // Busy held 10 cycles with A pending
        ba = done_a;
        br_busy = 1'b1;
        a_cmd = 1'b0; a_addr = 8'h55; a_req = 1'b1;
        repeat (10) @(posedge clk);
        #1 br_busy = 1'b0;
        push_read(1'b0, 8'h55, 64'h5500);
        @(negedge clk);
        chk("busy_cmd_en_release_cycle", br_cmd_en, 1'b0);
        @(negedge clk);
        chk("busy_cmd_en_next_cycle", br_cmd_en, 1'b1);
        wait_done(1'b0, ba, "busy_a");
        a_req = 1'b0;

        // Stray valid in IDLE
        repeat (2) @(posedge clk); #1;
        stray_data = 64'hDEAD_BEEF; stray_valid = 1'b1;
        @(negedge clk);
        chk("stray_rd_valid", {a_rd_valid, b_rd_valid}, 2'b00);
        @(posedge clk); #1 stray_valid = 1'b0;

        // Reset after read beat 2
        bb = done_b;
        rsp_stop = 2;
        exp_cmd_q.push_back({1'b0, 8'h77});
        for (int i = 0; i < 2; i++) begin
            exp_rd_q.push_back({1'b1, 64'h7700 + 64'(i)});
            bus_data_q.push_back(64'h7700 + 64'(i));
        end
        n = rd_seen;
        b_addr = 8'h77; b_req = 1'b1;
        for (int i = 0; i < 200 && rd_seen < n + 2; i++) @(posedge clk);
        chk("reset_test_beats_seen", rd_seen - n, 2);
        #1 rst = 1'b0; b_req = 1'b0;
        @(negedge clk);
        check_reset_vals("midburst_reset");
        repeat (3) @(posedge clk);
        chk("no_done_on_reset", done_b, bb);
        #1 rst = 1'b1; rsp_stop = 4;
        repeat (2) @(posedge clk); #1;

        // Normal read after reset release
        bb = done_b;
        push_read(1'b1, 8'h78, 64'h7800);
        b_addr = 8'h78; b_req = 1'b1;
        wait_done(1'b1, bb, "post_reset_b");
        b_req = 1'b0;
        repeat (4) @(posedge clk);

        chk("exp_cmd_drained", exp_cmd_q.size(), 0);
        chk("exp_rd_drained", exp_rd_q.size(), 0);
        chk("exp_wr_drained", exp_wr_q.size(), 0);
        chk("exp_done_drained", exp_done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
